// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - destination-register scoreboard producing forwarding selects, load-use stall and hazard code
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_src1_en,
  input  logic [REG_AW-1:0] id_src1,
  input  logic              id_src2_en,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_dst_en,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel1,
  output logic [SEL_W-1:0]  fwd_sel2,
  output logic [3:0]        hz_type,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Slots whose load data is not yet available for forwarding.
  localparam logic [DEPTH-1:0] LAT_MASK = DEPTH'((64'd1 << LOAD_LAT) - 64'd1);

  logic [DEPTH-1:0]  slot_v;
  logic [DEPTH-1:0]  slot_ld;
  logic [REG_AW-1:0] slot_dst [DEPTH];

  logic [DEPTH-1:0]  match1;
  logic [DEPTH-1:0]  match2;
  logic [SEL_W-1:0]  sel1_raw;
  logic [SEL_W-1:0]  sel2_raw;
  logic              load_use;
  logic              issue;

  // Per-slot source matches; register 0 is hardwired and never a hazard.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = id_valid & id_src1_en & slot_v[i] & (slot_dst[i] == id_src1) & (id_src1 != '0);
      match2[i] = id_valid & id_src2_en & slot_v[i] & (slot_dst[i] == id_src2) & (id_src2 != '0);
    end
  end

  // Youngest producer wins: scan oldest to youngest so the lowest index is assigned last.
  always_comb begin
    sel1_raw = '0;
    sel2_raw = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match1[i]) sel1_raw = SEL_W'(i + 1);
      if (match2[i]) sel2_raw = SEL_W'(i + 1);
    end
  end

  // Stall, forwarding and hazard classification for the decode instruction.
  always_comb begin
    load_use = |((match1 | match2) & slot_ld & LAT_MASK);
    stall    = load_use & ~flush;
    fwd_sel1 = stall ? '0 : sel1_raw;
    fwd_sel2 = stall ? '0 : sel2_raw;
    if (flush)
      hz_type = 4'd3;
    else if (stall)
      hz_type = 4'd2;
    else if ((fwd_sel1 != '0) || (fwd_sel2 != '0))
      hz_type = 4'd1;
    else
      hz_type = 4'd0;
    issue = id_valid & id_dst_en & ~stall & ~flush & (id_dst != '0);
  end

  // Slot pipeline: shifts every cycle, slot 0 takes the issuing instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v  <= '0;
      slot_ld <= '0;
      for (int i = 0; i < DEPTH; i++) slot_dst[i] <= '0;
    end else begin
      slot_v  <= {slot_v[DEPTH-2:0], issue};
      slot_ld <= {slot_ld[DEPTH-2:0], issue & id_is_load};
      for (int i = DEPTH - 1; i > 0; i--) slot_dst[i] <= slot_dst[i-1];
      slot_dst[0] <= issue ? id_dst : '0;
    end
  end

  // Saturating count of stall cycles for performance debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_src1_en, id_src2_en, id_dst_en, id_is_load, flush;
  logic [4:0] id_src1, id_src2, id_dst;

  logic        stall, stall_s;
  logic [1:0]  fwd_sel1, fwd_sel2, fwd_sel1_s, fwd_sel2_s;
  logic [3:0]  hz_type, hz_type_s;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_s;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src1_en(id_src1_en), .id_src1(id_src1),
    .id_src2_en(id_src2_en), .id_src2(id_src2),
    .id_dst_en(id_dst_en), .id_dst(id_dst), .id_is_load(id_is_load),
    .flush(flush), .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .hz_type(hz_type), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src1_en(id_src1_en), .id_src1(id_src1),
    .id_src2_en(id_src2_en), .id_src2(id_src2),
    .id_dst_en(id_dst_en), .id_dst(id_dst), .id_is_load(id_is_load),
    .flush(flush), .stall(stall_s), .fwd_sel1(fwd_sel1_s), .fwd_sel2(fwd_sel2_s),
    .hz_type(hz_type_s), .stall_cnt(stall_cnt_s)
  );

  // Reference model: list of in-flight producers, youngest first.
  logic       mv  [DEPTH];
  logic [4:0] mdst[DEPTH];
  logic       mld [DEPTH];
  int         mcnt, mcnt_s;

  function automatic int youngest(input logic en, input logic [4:0] r);
    if (!id_valid || !en || r == 5'd0) return -1;
    for (int i = 0; i < DEPTH; i++)
      if (mv[i] && mdst[i] == r) return i;
    return -1;
  endfunction

  function automatic logic m_stall();
    logic hit = 1'b0;
    if (flush) return 1'b0;
    for (int i = 0; i < LOAD_LAT; i++)
      if (mv[i] && mld[i] && id_valid && (
          (id_src1_en && id_src1 != 0 && mdst[i] == id_src1) ||
          (id_src2_en && id_src2 != 0 && mdst[i] == id_src2)))
        hit = 1'b1;
    return hit;
  endfunction

  function automatic int m_sel(input logic en, input logic [4:0] r);
    if (m_stall()) return 0;
    return youngest(en, r) + 1;
  endfunction

  function automatic int m_hz();
    if (flush) return 3;
    if (m_stall()) return 2;
    if (m_sel(id_src1_en, id_src1) != 0 || m_sel(id_src2_en, id_src2) != 0) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mv[i] <= 1'b0; mdst[i] <= 5'd0; mld[i] <= 1'b0;
      end
      mcnt   <= 0;
      mcnt_s <= 0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mv[i] <= mv[i-1]; mdst[i] <= mdst[i-1]; mld[i] <= mld[i-1];
      end
      if (id_valid && id_dst_en && !m_stall() && !flush && id_dst != 0) begin
        mv[0] <= 1'b1; mdst[0] <= id_dst; mld[0] <= id_is_load;
      end else begin
        mv[0] <= 1'b0; mdst[0] <= 5'd0; mld[0] <= 1'b0;
      end
      if (m_stall()) begin
        mcnt   <= (mcnt < 65535) ? mcnt + 1 : mcnt;
        mcnt_s <= (mcnt_s < 3) ? mcnt_s + 1 : mcnt_s;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_chk(input string tag);
    chk({tag, " stall"}, 32'(stall), 32'(m_stall()));
    chk({tag, " fwd_sel1"}, 32'(fwd_sel1), 32'(m_sel(id_src1_en, id_src1)));
    chk({tag, " fwd_sel2"}, 32'(fwd_sel2), 32'(m_sel(id_src2_en, id_src2)));
    chk({tag, " hz_type"}, 32'(hz_type), 32'(m_hz()));
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(mcnt));
    chk({tag, " stall_cnt_sat"}, 32'(stall_cnt_s), 32'(mcnt_s));
  endtask

  task automatic drive(input logic v, input logic s1e, input logic [4:0] s1,
                       input logic s2e, input logic [4:0] s2, input logic de,
                       input logic [4:0] d, input logic ld, input logic fl);
    id_valid = v; id_src1_en = s1e; id_src1 = s1; id_src2_en = s2e; id_src2 = s2;
    id_dst_en = de; id_dst = d; id_is_load = ld; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v, s1e; logic [4:0] s1; logic s2e; logic [4:0] s2;
    logic de; logic [4:0] d; logic ld, fl;
    logic st; logic [1:0] f1, f2; logic [3:0] hz; int cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic s1e, input logic [4:0] s1,
                              input logic s2e, input logic [4:0] s2, input logic de,
                              input logic [4:0] d, input logic ld, input logic fl,
                              input logic st, input logic [1:0] f1, input logic [1:0] f2,
                              input logic [3:0] hz, input int cnt);
    vec_t r;
    r.v = v; r.s1e = s1e; r.s1 = s1; r.s2e = s2e; r.s2 = s2; r.de = de; r.d = d;
    r.ld = ld; r.fl = fl; r.st = st; r.f1 = f1; r.f2 = f2; r.hz = hz; r.cnt = cnt;
    return r;
  endfunction

  vec_t vecs[17];

  initial begin
    //             v s1e s1  s2e s2  de d   ld fl  st f1 f2 hz cnt
    vecs[0]  = mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0); // idle after reset
    vecs[1]  = mk(1, 1, 1,  1, 2,  1, 3,  0, 0,  0, 0, 0, 0, 0); // add r3
    vecs[2]  = mk(1, 1, 3,  1, 3,  0, 0,  0, 0,  0, 1, 1, 1, 0); // consumer, distance 1
    vecs[3]  = mk(1, 0, 0,  0, 0,  1, 3,  0, 0,  0, 0, 0, 0, 0); // add r3
    vecs[4]  = mk(1, 0, 0,  0, 0,  1, 9,  0, 0,  0, 0, 0, 0, 0); // unrelated r9
    vecs[5]  = mk(1, 1, 3,  1, 0,  0, 0,  0, 0,  0, 2, 0, 1, 0); // one between -> 2
    vecs[6]  = mk(1, 1, 3,  1, 9,  0, 0,  0, 0,  0, 3, 2, 1, 0); // two between -> 3
    vecs[7]  = mk(1, 0, 0,  0, 0,  1, 5,  1, 0,  0, 0, 0, 0, 0); // lw r5
    vecs[8]  = mk(1, 0, 0,  1, 5,  1, 6,  0, 0,  1, 0, 0, 2, 0); // load-use stall
    vecs[9]  = mk(1, 0, 0,  1, 5,  1, 6,  0, 0,  0, 0, 2, 1, 1); // re-presented
    vecs[10] = mk(1, 0, 0,  0, 0,  1, 0,  0, 0,  0, 0, 0, 0, 1); // add r0
    vecs[11] = mk(1, 1, 0,  1, 0,  1, 7,  0, 0,  0, 0, 0, 0, 1); // reads r0, writes r7
    vecs[12] = mk(1, 0, 0,  0, 0,  1, 7,  0, 0,  0, 0, 0, 0, 1); // r7 again
    vecs[13] = mk(1, 1, 7,  1, 7,  0, 0,  0, 0,  0, 1, 1, 1, 1); // youngest r7 wins
    vecs[14] = mk(1, 0, 0,  0, 0,  1, 4,  1, 0,  0, 0, 0, 0, 1); // lw r4
    vecs[15] = mk(1, 1, 4,  0, 0,  1, 8,  0, 1,  0, 1, 0, 3, 1); // consumer flushed
    vecs[16] = mk(1, 1, 8,  1, 4,  0, 0,  0, 0,  0, 0, 2, 1, 1); // killed r8 left nothing

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      drive(vecs[k].v, vecs[k].s1e, vecs[k].s1, vecs[k].s2e, vecs[k].s2,
            vecs[k].de, vecs[k].d, vecs[k].ld, vecs[k].fl);
      #1;
      chk($sformatf("vec%0d stall", k), 32'(stall), 32'(vecs[k].st));
      chk($sformatf("vec%0d fwd_sel1", k), 32'(fwd_sel1), 32'(vecs[k].f1));
      chk($sformatf("vec%0d fwd_sel2", k), 32'(fwd_sel2), 32'(vecs[k].f2));
      chk($sformatf("vec%0d hz_type", k), 32'(hz_type), 32'(vecs[k].hz));
      chk($sformatf("vec%0d stall_cnt", k), 32'(stall_cnt), 32'(vecs[k].cnt));
      tick();
    end

    // Five more load-use stalls: narrow counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
      #1; tick();
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
      #1; chk($sformatf("sat%0d stall", k), 32'(stall), 32'd1);
      tick();
      #1; chk($sformatf("sat%0d release", k), 32'(stall), 32'd0);
      tick();
    end
    chk("sat stall_cnt_sat", 32'(stall_cnt_s), 32'd3);
    chk("sat stall_cnt", 32'(stall_cnt), 32'd6);

    // Asynchronous reset with a load in flight and its consumer waiting.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    #1; tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
    #1; chk("pre-reset stall", 32'(stall), 32'd1);
    #1; rst_n = 1'b0;
    #1;
    chk("async rst stall", 32'(stall), 32'd0);
    chk("async rst fwd_sel1", 32'(fwd_sel1), 32'd0);
    chk("async rst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async rst stall_cnt_sat", 32'(stall_cnt_s), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post rst hz_type", 32'(hz_type), 32'd0);
    tick();
    #1; model_chk("post rst");

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 7) != 0),
            1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0));
      #1;
      model_chk($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
